set_field_pipe: RTL and testbench
=================================

# set_field_pipe

Registered, multi-field successor to the single-field combinational field writer in the action pipeline. Each beat of the packet-header stream arrives with a descriptor carrying up to FIELD_NUM field-set operations. Each operation has its own runtime byte offset, data and byte-enable mask. The block applies all operations with a fixed priority and emits the rewritten beat two cycles later behind a valid/ready handshake. It sits between the match-table lookup result merge and the header deparser.

## Interface
Parameters:
- DATA_WIDTH, 600 — stream data width in bits; must be a multiple of 8.
- FIELD_NUM, 4 — number of field operations per beat; range 1..8.
- FIELD_WIDTH, 48 — bits per field operation; must be a multiple of 8 and ≤ DATA_WIDTH.
- OFFSET_WIDTH, $clog2(DATA_WIDTH/8) — width of each byte offset.
- STAT_WIDTH, 32 — statistics counter width.

Ports:
- clk — in, 1 — clock.
- rst — in, 1 — asynchronous, active-high reset.
- s_data — in, DATA_WIDTH — input beat.
- s_last — in, 1 — last beat of packet; passed through unchanged.
- s_fld_en — in, FIELD_NUM — per-field enable.
- s_fld_off — in, FIELD_NUM*OFFSET_WIDTH — byte offset of each field.
- s_fld_data — in, FIELD_NUM*FIELD_WIDTH — data for each field.
- s_fld_mask — in, FIELD_NUM*FIELD_WIDTH/8 — byte enable for each field.
- s_valid — in, 1; s_ready — out, 1 — input handshake.
- m_data — out, DATA_WIDTH — rewritten beat.
- m_last — out, 1 — pass-through of s_last.
- m_valid — out, 1; m_ready — in, 1 — output handshake.
- stat_beats — out, STAT_WIDTH — count of beats accepted.
- stat_oob — out, STAT_WIDTH — count of beats with at least one out-of-range enabled byte.

## Operation
- Byte k of the stream is data[8k+7:8k]. Field i, byte j is fld_data[i][8j+7:8j]. That byte targets stream byte fld_off[i]+j and is written only when fld_en[i]=1 and fld_mask[i][j]=1.
- Priority on overlap: the highest field index wins. Bytes not targeted pass through unchanged.
- Out-of-range target (fld_off[i]+j ≥ DATA_WIDTH/8, computed without truncation): the byte is dropped and the beat is flagged out-of-band. A flagged beat increments stat_oob once, regardless of how many bytes were dropped. The beat is still forwarded.
- All enables 0 or all masks 0: the beat passes through bit-exact.
- Stage 1 registers the data, last, and a per-output-byte select (field index plus byte index, and a hit flag) computed from the descriptors. The descriptors themselves are not kept past stage 1.
- Stage 2 registers the muxed output bytes, last, and valid.
- Counters wrap modulo 2^STAT_WIDTH. stat_beats increments on every accepted input beat (s_valid && s_ready).

## Timing
- Latency is exactly 2 cycles from input acceptance to m_valid while m_ready stays high. Throughput is 1 beat per cycle.
- Pipeline advance: adv = !m_valid || m_ready. s_ready = adv || !s1_valid; this is combinational from m_ready.
- m_valid holds, and m_data/m_last stay stable, while m_valid && !m_ready.
- m_ready low while both stages are full: s_ready=0. No beat is lost or duplicated.
- Simultaneous accept and emit in the same cycle: both occur, and occupancy is unchanged.
- Reset, including mid-packet: m_valid=0, m_data=0, m_last=0, stat_beats=0, stat_oob=0, and stage 1 is emptied. s_ready=1 in the first cycle after reset deasserts. In-flight beats are discarded.
- s_* inputs are ignored when s_valid=0. Descriptor inputs are sampled only on acceptance.

## Structure
- The shared action package holds BYTE_W=8 and the descriptor packing macros/functions: field slice of s_fld_off, s_fld_data and s_fld_mask by index. The same packing is used by the table result merge.
- One sub-module, set_field_lane: per output byte, it takes the byte index and all descriptors and produces the hit, field index, byte index and out-of-range contribution. It is instantiated DATA_WIDTH/8 times with a generate loop.
- Top level: stage registers, handshake, output mux and counters.

## Test plan
- Single field, off=12, data=48'h0A0B0C0D0E0F, mask=6'h3F, m_ready=1 -> output bytes 12..17 = 0F,0E,0D,0C,0B,0A; all other bytes unchanged; m_valid 2 cycles after accept.
- Fields 0 and 3 both at off=20, with field 3 mask=6'b000101 -> bytes 20 and 22 from field 3; bytes 21, 23, 24 and 25 from field 0.
- off=72, mask=6'h3F on a 75-byte bus -> bytes 72..74 written; beat forwarded; stat_oob=1; stat_beats=1.
- Back-to-back 100 beats with m_ready randomly toggled -> output order and data match the model; no drops or duplicates; s_ready=0 only when both stages are full and m_ready=0; stat_beats=100.
- All s_fld_en=0 -> m_data identical to s_data and m_last identical to s_last for 10 beats.
- rst asserted with 2 beats in flight and m_ready=0 -> m_valid=0, m_data=0 and counters=0 immediately. After release, a new beat emerges at latency 2 with no stale data.

Source files
------------

// File: rtl/set_field_pipe_pkg.sv
// set_field_pipe_pkg: shared action constants and descriptor slicing helpers
`define SFP_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
package set_field_pipe_pkg;
    localparam int BYTE_W = 8;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/set_field_lane.sv
// set_field_lane: per-output-byte field select and out-of-range detection
module set_field_lane
    import set_field_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 600,
    parameter int FIELD_NUM = 4,
    parameter int FIELD_WIDTH = 48,
    parameter int OFFSET_WIDTH = 7,
    parameter int BYTE_IDX = 0,
    localparam int FB = FIELD_WIDTH / BYTE_W,
    localparam int FIW = idx_w(FIELD_NUM),
    localparam int FBW = idx_w(FB)
) (
    input  logic [FIELD_NUM-1:0]              fld_en,
    input  logic [FIELD_NUM*OFFSET_WIDTH-1:0] fld_off,
    input  logic [FIELD_NUM*FB-1:0]           fld_mask,
    output logic                              hit,
    output logic [FIW-1:0]                    fld,
    output logic [FBW-1:0]                    byt,
    output logic                              oob
);
    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam int OJ = BYTE_IDX < FB ? BYTE_IDX : 0;
    logic [OFFSET_WIDTH-1:0] off [FIELD_NUM];
    logic [FB-1:0]           msk [FIELD_NUM];
    for (genvar g = 0; g < FIELD_NUM; g++) begin : g_fld
        assign off[g] = `SFP_SLICE(fld_off, g, OFFSET_WIDTH);
        assign msk[g] = `SFP_SLICE(fld_mask, g, FB);
    end
    // Lane k also judges field byte j=k for range, so every field byte is checked exactly once.
    always_comb begin
        hit = 1'b0;
        fld = '0;
        byt = '0;
        oob = 1'b0;
        for (int i = 0; i < FIELD_NUM; i++) begin
            for (int j = 0; j < FB; j++)
                if (fld_en[i] && msk[i][j] && j <= BYTE_IDX && int'(off[i]) == BYTE_IDX - j) begin
                    hit = 1'b1;
                    fld = FIW'(i);
                    byt = FBW'(j);
                end
            if (BYTE_IDX < FB && fld_en[i] && msk[i][OJ] && int'(off[i]) + OJ >= NB)
                oob = 1'b1;
        end
    end
endmodule

// File: rtl/set_field_pipe.sv
// set_field_pipe: two-stage multi-field byte rewriter with valid/ready handshake
module set_field_pipe
    import set_field_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 600,
    parameter int FIELD_NUM = 4,
    parameter int FIELD_WIDTH = 48,
    parameter int OFFSET_WIDTH = $clog2(DATA_WIDTH / 8),
    parameter int STAT_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               s_data,
    input  logic                                s_last,
    input  logic [FIELD_NUM-1:0]                s_fld_en,
    input  logic [FIELD_NUM*OFFSET_WIDTH-1:0]   s_fld_off,
    input  logic [FIELD_NUM*FIELD_WIDTH-1:0]    s_fld_data,
    input  logic [FIELD_NUM*FIELD_WIDTH/8-1:0]  s_fld_mask,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [DATA_WIDTH-1:0]               m_data,
    output logic                                m_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [STAT_WIDTH-1:0]               stat_beats,
    output logic [STAT_WIDTH-1:0]               stat_oob
);
    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam int FB = FIELD_WIDTH / BYTE_W;
    localparam int FIW = idx_w(FIELD_NUM);
    localparam int FBW = idx_w(FB);
    logic [NB-1:0]                           lane_hit, lane_oob, s1_hit;
    logic [NB-1:0][FIW-1:0]                  lane_fld, s1_fld;
    logic [NB-1:0][FBW-1:0]                  lane_byt, s1_byt;
    logic [NB-1:0][BYTE_W-1:0]               s1_data, mux;
    logic [FIELD_NUM-1:0][FB-1:0][BYTE_W-1:0] s1_fdata;
    logic s1_valid, s1_last, adv, acc;
    for (genvar g = 0; g < NB; g++) begin : g_lane
        set_field_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIELD_NUM(FIELD_NUM),
            .FIELD_WIDTH(FIELD_WIDTH),
            .OFFSET_WIDTH(OFFSET_WIDTH),
            .BYTE_IDX(g)
        ) u_lane (
            .fld_en(s_fld_en),
            .fld_off(s_fld_off),
            .fld_mask(s_fld_mask),
            .hit(lane_hit[g]),
            .fld(lane_fld[g]),
            .byt(lane_byt[g]),
            .oob(lane_oob[g])
        );
    end
    assign adv = !m_valid || m_ready;
    assign s_ready = adv || !s1_valid;
    assign acc = s_valid && s_ready;
    always_comb begin
        mux = s1_data;
        for (int k = 0; k < NB; k++)
            if (s1_hit[k]) mux[k] = s1_fdata[s1_fld[k]][s1_byt[k]];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            stat_beats <= '0;
            stat_oob   <= '0;
        end else begin
            if (s_ready) s1_valid <= s_valid;
            if (adv) m_valid <= s1_valid;
            if (adv && s1_valid) begin
                m_data <= mux;
                m_last <= s1_last;
            end
            if (acc) begin
                stat_beats <= stat_beats + 1'b1;
                stat_oob   <= stat_oob + STAT_WIDTH'(|lane_oob);
            end
        end
    end
    // Payload registers need no reset: s1_valid gates everything downstream.
    always_ff @(posedge clk) begin
        if (acc) begin
            s1_data  <= s_data;
            s1_last  <= s_last;
            s1_fdata <= s_fld_data;
            s1_hit   <= lane_hit;
            s1_fld   <= lane_fld;
            s1_byt   <= lane_byt;
        end
    end
endmodule

// File: tb/tb_set_field_pipe.sv
// tb_set_field_pipe: directed self-checking bench for set_field_pipe
module tb_set_field_pipe;
    localparam int DW = 600, FN = 4, FW = 48, OW = 7, FB = 6, NB = 75, SW = 32;
    logic clk = 1'b0, rst;
    logic [DW-1:0] s_data, m_data;
    logic s_last, s_valid, s_ready, m_last, m_valid, m_ready;
    logic [FN-1:0] s_fld_en;
    logic [FN*OW-1:0] s_fld_off;
    logic [FN*FW-1:0] s_fld_data;
    logic [FN*FB-1:0] s_fld_mask;
    logic [SW-1:0] stat_beats, stat_oob;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    set_field_pipe #(
        .DATA_WIDTH(DW), .FIELD_NUM(FN), .FIELD_WIDTH(FW), .OFFSET_WIDTH(OW), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_fld_en(s_fld_en),
        .s_fld_off(s_fld_off), .s_fld_data(s_fld_data), .s_fld_mask(s_fld_mask),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .stat_beats(stat_beats), .stat_oob(stat_oob)
    );

    function automatic logic [DW-1:0] rand_vec();
        logic [639:0] t;
        for (int w = 0; w < 20; w++) t[w*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [FN-1:0] en,
        input logic [FN*OW-1:0] off, input logic [FN*FW-1:0] fd, input logic [FN*FB-1:0] mk,
        output bit oob);
        logic [DW-1:0] r;
        int t;
        r = d;
        oob = 1'b0;
        for (int i = 0; i < FN; i++)
            for (int j = 0; j < FB; j++)
                if (en[i] && mk[i*FB+j]) begin
                    t = int'(off[i*OW +: OW]) + j;
                    if (t < NB) r[t*8 +: 8] = fd[i*FW + j*8 +: 8];
                    else oob = 1'b1;
                end
        return r;
    endfunction

    task automatic idle();
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        s_fld_en = '0;
        s_fld_off = '0;
        s_fld_data = '0;
        s_fld_mask = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        total++; if (stat_beats !== '0) begin bad++; $display("FAIL reset_stat_beats got=%0d exp=0", stat_beats); end
        total++; if (stat_oob !== '0) begin bad++; $display("FAIL reset_stat_oob got=%0d exp=0", stat_oob); end
        rst = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_single();
        logic [DW-1:0] d, exp;
        do_reset();
        d = rand_vec();
        exp = d;
        exp[12*8 +: 48] = 48'h0A0B0C0D0E0F;
        s_data = d; s_last = 1'b1; s_valid = 1'b1;
        s_fld_en = 4'b0001;
        s_fld_off[0 +: OW] = 7'd12;
        s_fld_data[0 +: FW] = 48'h0A0B0C0D0E0F;
        s_fld_mask[0 +: FB] = 6'h3F;
        @(negedge clk);
        idle();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_lat1_valid got=%b exp=0", m_valid); end
        @(negedge clk);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_lat2_valid got=%b exp=1", m_valid); end
        total++; if (m_data !== exp) begin bad++; $display("FAIL single_data got=%h exp=%h", m_data, exp); end
        total++; if (m_last !== 1'b1) begin bad++; $display("FAIL single_last got=%b exp=1", m_last); end
    endtask

    task automatic test_overlap();
        logic [DW-1:0] d, exp;
        do_reset();
        d = rand_vec();
        exp = d;
        exp[20*8 +: 48] = 48'h665544CC22AA;
        s_data = d; s_valid = 1'b1;
        s_fld_en = 4'b1001;
        s_fld_off[0*OW +: OW] = 7'd20;
        s_fld_off[3*OW +: OW] = 7'd20;
        s_fld_data[0*FW +: FW] = 48'h665544332211;
        s_fld_data[3*FW +: FW] = 48'hFFEEDDCCBBAA;
        s_fld_mask[0*FB +: FB] = 6'h3F;
        s_fld_mask[3*FB +: FB] = 6'b000101;
        @(negedge clk);
        idle();
        @(negedge clk);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL overlap_valid got=%b exp=1", m_valid); end
        total++; if (m_data !== exp) begin bad++; $display("FAIL overlap_data got=%h exp=%h", m_data, exp); end
    endtask

    task automatic test_oob();
        logic [DW-1:0] d, exp;
        do_reset();
        d = rand_vec();
        exp = d;
        exp[72*8 +: 24] = 24'h030201;
        s_data = d; s_valid = 1'b1;
        s_fld_en = 4'b0001;
        s_fld_off[0 +: OW] = 7'd72;
        s_fld_data[0 +: FW] = 48'h060504030201;
        s_fld_mask[0 +: FB] = 6'h3F;
        @(negedge clk);
        idle();
        @(negedge clk);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL oob_valid got=%b exp=1", m_valid); end
        total++; if (m_data !== exp) begin bad++; $display("FAIL oob_data got=%h exp=%h", m_data, exp); end
        total++; if (stat_oob !== 32'd1) begin bad++; $display("FAIL oob_stat_oob got=%0d exp=1", stat_oob); end
        total++; if (stat_beats !== 32'd1) begin bad++; $display("FAIL oob_stat_beats got=%0d exp=1", stat_beats); end
    endtask

    task automatic test_passthru();
        logic [DW-1:0] d [10];
        logic l [10];
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            if (c < 10) begin
                d[c] = rand_vec();
                l[c] = 1'($urandom_range(0, 1));
                s_data = d[c]; s_last = l[c]; s_valid = 1'b1;
                s_fld_en = '0;
                s_fld_off = 28'($urandom);
                s_fld_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                s_fld_mask = '1;
            end else idle();
            @(negedge clk);
            if (c >= 1) begin
                total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL passthru_valid[%0d] got=%b exp=1", c-1, m_valid); end
                total++; if (m_data !== d[c-1]) begin bad++; $display("FAIL passthru_data[%0d] got=%h exp=%h", c-1, m_data, d[c-1]); end
                total++; if (m_last !== l[c-1]) begin bad++; $display("FAIL passthru_last[%0d] got=%b exp=%b", c-1, m_last, l[c-1]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [$];
        logic exp_l [$];
        logic [DW-1:0] ed, hold_d;
        bit o, acc, hold;
        int sent, got, n_oob;
        sent = 0; got = 0; n_oob = 0; acc = 1'b0; hold = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
            if (acc) s_valid = 1'b0;
            m_ready = 1'($urandom_range(0, 1));
            if (!s_valid && sent < 100) begin
                s_data = rand_vec();
                s_last = 1'($urandom_range(0, 1));
                s_fld_en = 4'($urandom);
                for (int i = 0; i < FN; i++) s_fld_off[i*OW +: OW] = 7'($urandom_range(0, 78));
                s_fld_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                s_fld_mask = 24'($urandom);
                s_valid = 1'b1;
            end
            #1;
            total++;
            if (s_ready !== !(exp_d.size() == 2 && !m_ready)) begin
                bad++; $display("FAIL b2b_s_ready cyc=%0d got=%b inflight=%0d m_ready=%b", cyc, s_ready, exp_d.size(), m_ready);
            end
            if (hold) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== hold_d) begin
                    bad++; $display("FAIL b2b_stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, m_valid, m_data, hold_d);
                end
            end
            hold = m_valid && !m_ready;
            hold_d = m_data;
            if (m_valid && m_ready) begin
                total++;
                if (exp_d.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_beat cyc=%0d got=%h", cyc, m_data);
                end else begin
                    ed = exp_d.pop_front();
                    if (m_data !== ed || m_last !== exp_l[0]) begin
                        bad++; $display("FAIL b2b_beat[%0d] got=%h/%b exp=%h/%b", got, m_data, m_last, ed, exp_l[0]);
                    end
                    void'(exp_l.pop_front());
                end
                got++;
            end
            acc = s_valid && s_ready;
            if (acc) begin
                exp_d.push_back(model(s_data, s_fld_en, s_fld_off, s_fld_data, s_fld_mask, o));
                exp_l.push_back(s_last);
                n_oob += int'(o);
                sent++;
            end
            @(negedge clk);
        end
        idle();
        total++; if (got != 100) begin bad++; $display("FAIL b2b_count got=%0d exp=100", got); end
        total++; if (stat_beats !== 32'd100) begin bad++; $display("FAIL b2b_stat_beats got=%0d exp=100", stat_beats); end
        total++; if (stat_oob !== SW'(n_oob)) begin bad++; $display("FAIL b2b_stat_oob got=%0d exp=%0d", stat_oob, n_oob); end
    endtask

    task automatic test_reset_inflight();
        logic [DW-1:0] c;
        logic cl;
        do_reset();
        m_ready = 1'b0;
        s_data = rand_vec(); s_valid = 1'b1;
        s_fld_en = 4'b0001;
        s_fld_off[0 +: OW] = 7'd72;
        s_fld_data[0 +: FW] = 48'h060504030201;
        s_fld_mask[0 +: FB] = 6'h3F;
        @(negedge clk);
        s_data = rand_vec(); s_fld_en = '0;
        @(negedge clk);
        idle();
        #1;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL inflight_full_valid got=%b exp=1", m_valid); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL inflight_full_s_ready got=%b exp=0", s_ready); end
        total++; if (stat_oob !== 32'd1) begin bad++; $display("FAIL inflight_pre_oob got=%0d exp=1", stat_oob); end
        rst = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL inflight_rst_valid got=%b exp=0", m_valid); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL inflight_rst_data got=%h exp=0", m_data); end
        total++; if (stat_beats !== '0) begin bad++; $display("FAIL inflight_rst_beats got=%0d exp=0", stat_beats); end
        total++; if (stat_oob !== '0) begin bad++; $display("FAIL inflight_rst_oob got=%0d exp=0", stat_oob); end
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        c = rand_vec();
        cl = 1'b1;
        s_data = c; s_last = cl; s_valid = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL inflight_post_s_ready got=%b exp=1", s_ready); end
        @(negedge clk);
        idle();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL inflight_stale_valid got=%b exp=0", m_valid); end
        @(negedge clk);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL inflight_new_valid got=%b exp=1", m_valid); end
        total++; if (m_data !== c) begin bad++; $display("FAIL inflight_new_data got=%h exp=%h", m_data, c); end
        total++; if (m_last !== cl) begin bad++; $display("FAIL inflight_new_last got=%b exp=%b", m_last, cl); end
        total++; if (stat_beats !== 32'd1) begin bad++; $display("FAIL inflight_new_beats got=%0d exp=1", stat_beats); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_oob();
        test_passthru();
        test_back_to_back();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
